// File: rtl/mem_interconnect.sv
// Data-memory interconnect: decodes the host load/store port onto N fixed-latency slaves,
// tracks outstanding reads by return slot, and muxes read data/error responses back in order.
module mem_interconnect #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned N_SLAVES = 3,
    parameter int unsigned MAX_LAT  = 4,
    parameter logic [N_SLAVES*XLEN-1:0] SLAVE_BASE = {32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [N_SLAVES*XLEN-1:0] SLAVE_MASK = {32'hFFFF_0000, 32'hFFFE_0000, 32'hFFFC_0000},
    parameter logic [N_SLAVES*4-1:0]    SLAVE_LAT  = {4'd2, 4'd1, 4'd1},
    parameter logic [N_SLAVES-1:0]      SLAVE_RO   = 3'b001
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     h_req,
    input  logic                     h_we,
    input  logic [XLEN-1:0]          h_addr,
    input  logic [XLEN/8-1:0]        h_byteen,
    input  logic [XLEN-1:0]          h_wdata,
    output logic                     h_ready,
    output logic                     h_rvalid,
    output logic [XLEN-1:0]          h_rdata,
    output logic                     h_err,
    output logic [N_SLAVES-1:0]      s_req,
    output logic [N_SLAVES-1:0]      s_we,
    output logic [XLEN-1:0]          s_addr,
    output logic [XLEN/8-1:0]        s_byteen,
    output logic [XLEN-1:0]          s_wdata,
    input  logic [N_SLAVES*XLEN-1:0] s_rdata
);

    localparam int unsigned IW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    logic           hit;
    logic [IW-1:0]  hit_idx;
    logic [3:0]     hit_lat;
    logic           hit_ro;
    logic           err_req;
    logic           track;
    logic [3:0]     req_lat;
    logic           slot_busy;
    logic           accept;

    logic           t_valid [1:MAX_LAT];
    logic           t_err   [1:MAX_LAT];
    logic [IW-1:0]  t_idx   [1:MAX_LAT];

    // Address decode; scanning downwards lets the lowest matching index win.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        hit_lat = 4'd1;
        hit_ro  = 1'b0;
        for (int i = int'(N_SLAVES) - 1; i >= 0; i--) begin
            if ((h_addr & SLAVE_MASK[i*XLEN +: XLEN]) == SLAVE_BASE[i*XLEN +: XLEN]) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
                hit_lat = SLAVE_LAT[i*4 +: 4];
                hit_ro  = SLAVE_RO[i];
            end
        end
    end

    // A request produces a response unless it is a clean write; stall if its return slot is taken.
    always_comb begin
        err_req   = !hit || (h_we && hit_ro);
        track     = err_req || !h_we;
        req_lat   = err_req ? 4'd1 : hit_lat;
        slot_busy = 1'b0;
        for (int k = 2; k <= int'(MAX_LAT); k++) begin
            if (k == int'(req_lat) + 1) begin
                slot_busy = t_valid[k];
            end
        end
        h_ready = !rst && !(track && slot_busy);
        accept  = h_req && h_ready;
    end

    always_comb begin
        for (int i = 0; i < int'(N_SLAVES); i++) begin
            s_req[i] = accept && !err_req && (hit_idx == IW'(i));
        end
        s_we     = s_req & {N_SLAVES{h_we}};
        s_addr   = h_addr;
        s_byteen = h_byteen;
        s_wdata  = h_wdata;
    end

    // Return tracker: entry k retires in k cycles; new reads land at their latency slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k <= int'(MAX_LAT); k++) begin
                t_valid[k] <= 1'b0;
                t_err[k]   <= 1'b0;
                t_idx[k]   <= '0;
            end
        end else begin
            for (int k = 1; k < int'(MAX_LAT); k++) begin
                t_valid[k] <= t_valid[k+1];
                t_err[k]   <= t_err[k+1];
                t_idx[k]   <= t_idx[k+1];
            end
            t_valid[MAX_LAT] <= 1'b0;
            t_err[MAX_LAT]   <= 1'b0;
            t_idx[MAX_LAT]   <= '0;
            if (accept && track) begin
                for (int k = 1; k <= int'(MAX_LAT); k++) begin
                    if (k == int'(req_lat)) begin
                        t_valid[k] <= 1'b1;
                        t_err[k]   <= err_req;
                        t_idx[k]   <= hit_idx;
                    end
                end
            end
        end
    end

    always_comb begin
        h_rvalid = t_valid[1];
        h_err    = t_valid[1] && t_err[1];
        h_rdata  = '0;
        if (t_valid[1] && !t_err[1]) begin
            for (int i = 0; i < int'(N_SLAVES); i++) begin
                if (t_idx[1] == IW'(i)) begin
                    h_rdata = s_rdata[i*XLEN +: XLEN];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_interconnect.sv
// Scoreboard bench for mem_interconnect: directed scenarios then random traffic,
// checked against an address-range/return-cycle reference model.
module tb_mem_interconnect;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NS   = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               h_req, h_we;
    logic [XLEN-1:0]    h_addr, h_wdata;
    logic [XLEN/8-1:0]  h_byteen;
    logic               h_ready, h_rvalid, h_err;
    logic [XLEN-1:0]    h_rdata;
    logic [NS-1:0]      s_req, s_we;
    logic [XLEN-1:0]    s_addr, s_wdata;
    logic [XLEN/8-1:0]  s_byteen;
    logic [NS*XLEN-1:0] s_rdata;

    mem_interconnect dut (
        .clk(clk), .rst(rst), .h_req(h_req), .h_we(h_we), .h_addr(h_addr),
        .h_byteen(h_byteen), .h_wdata(h_wdata), .h_ready(h_ready), .h_rvalid(h_rvalid),
        .h_rdata(h_rdata), .h_err(h_err), .s_req(s_req), .s_we(s_we), .s_addr(s_addr),
        .s_byteen(s_byteen), .s_wdata(s_wdata), .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slaves return a word unique to (cycle, slave), so data proves both timing and routing.
    function automatic logic [31:0] slave_word(input int c, input int i);
        return (32'(c) * 32'h9E37_79B1) ^ (32'(i) << 29) ^ 32'h1234_5678;
    endfunction

    always_comb begin
        for (int i = 0; i < int'(NS); i++) s_rdata[i*XLEN +: XLEN] = slave_word(cyc, i);
    end

    typedef struct {
        int cyc;
        bit err;
        int idx;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Memory map as address ranges: ROM 256KB @0 (RO), RAM 128KB @0x1000_0000, periph 64KB @0x2000_0000.
    task automatic ref_decode(input logic [31:0] a, input logic we,
                              output int idx, output bit err, output int lat);
        idx = -1;
        if (a < 32'h0004_0000) idx = 0;
        else if (a >= 32'h1000_0000 && a < 32'h1002_0000) idx = 1;
        else if (a >= 32'h2000_0000 && a < 32'h2001_0000) idx = 2;
        err = (idx < 0) || (we && idx == 0);
        lat = err ? 1 : ((idx == 2) ? 2 : 1);
    endtask

    function automatic bit slot_taken(input int c);
        foreach (sb[j]) if (sb[j].cyc == c) return 1'b1;
        return 1'b0;
    endfunction

    // Presents one request (called at posedge+1) and holds it until accepted.
    task automatic issue(input logic we, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] wd, output int waits);
        int idx, lat;
        bit err, track, exp_ready;
        logic [2:0] exp_sreq;
        ref_decode(a, we, idx, err, lat);
        track    = err || !we;
        exp_sreq = err ? 3'b000 : 3'(1 << idx);
        h_req = 1'b1; h_we = we; h_addr = a; h_byteen = be; h_wdata = wd;
        waits = 0;
        forever begin
            #2;
            exp_ready = !(track && slot_taken(cyc + lat));
            check("h_ready", 96'(h_ready), 96'(exp_ready));
            if (h_ready) begin
                check("s_req_we", {s_req, s_we}, {exp_sreq, we ? exp_sreq : 3'b000});
                check("s_bus", {s_addr, s_byteen, s_wdata}, {a, be, wd});
                if (track) sb.push_back('{cyc + lat, err, idx});
                @(posedge clk); #1;
                break;
            end
            check("stalled_s_req", {s_req, s_we}, 96'(0));
            waits++;
            if (waits > 20) begin
                check("accept_timeout", 96'(1), 96'(0));
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int n);
        h_req = 1'b0;
        h_addr = $urandom;
        h_we = 1'($urandom);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compares every response cycle against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            check("reset_outs", {h_rvalid, h_err, h_ready, s_req, s_we, h_rdata}, 96'(0));
        end else begin
            if (!h_req) check("no_req_strobe", {s_req, s_we}, 96'(0));
            if (h_rvalid) begin
                if (sb.size() == 0) begin
                    check("spurious_rvalid", 96'(1), 96'(0));
                end else begin
                    e = sb.pop_front();
                    check("resp_cycle", 96'(cyc), 96'(e.cyc));
                    check("resp_err", 96'(h_err), 96'(e.err));
                    check("resp_data", 96'(h_rdata), e.err ? 96'(0) : 96'(slave_word(cyc, e.idx)));
                end
            end else begin
                check("idle_resp", {h_err, h_rdata}, 96'(0));
                if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                    check("missing_rvalid", 96'(0), 96'(1));
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int w;
        logic [31:0] a;
        logic we;
        h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_byteen = '0; h_wdata = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        issue(1'b0, 32'h1000_0010, 4'hF, 32'h0, w);
        issue(1'b1, 32'h0000_0100, 4'hF, 32'h1111_2222, w);
        issue(1'b0, 32'h3000_0000, 4'hF, 32'h0, w);
        idle(3);

        // Periph (2-cycle) read followed by RAM read must stall exactly one cycle.
        issue(1'b0, 32'h2000_0004, 4'hF, 32'h0, w);
        issue(1'b0, 32'h1000_0000, 4'hF, 32'h0, w);
        check("collision_stall", 96'(w), 96'(1));
        idle(3);

        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 32'h1000_0000 + 32'(4 * i), 4'hF, 32'h0, w);
            check("b2b_no_stall", 96'(w), 96'(0));
        end
        idle(3);

        // Reset with a periph read in flight: the response is dropped.
        issue(1'b0, 32'h2000_0000, 4'hF, 32'h0, w);
        h_req = 1'b0;
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);
        issue(1'b0, 32'h2000_0008, 4'hF, 32'h0, w);
        idle(4);

        repeat (400) begin
            case ($urandom_range(0, 9))
                0, 1, 2: a = 32'h0000_0000 + ($urandom & 32'h0003_FFFC);
                3, 4, 5: a = 32'h1000_0000 + ($urandom & 32'h0001_FFFC);
                6, 7:    a = 32'h2000_0000 + ($urandom & 32'h0000_FFFC);
                8:       a = 32'h1002_0000 + ($urandom & 32'h0000_00FC);
                default: a = $urandom;
            endcase
            we = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
            issue(we, a, 4'($urandom), $urandom, w);
        end
        idle(6);
        check("scoreboard_drained", 96'(sb.size()), 96'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
